// File: rtl/booth_pkg.sv
// ============================================================================
// Module  : booth_pkg
// Brief   : Shared FSM state encoding and Booth operation codes for booth_seq_mult.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
    ST_DONE = S_DONE
  } state_t;

  // Booth recoding of the pair {Q[0], Q_-1}
  localparam logic [1:0] OP_HOLD0 = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_HOLD1 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
// Module  : booth_step
// Brief   : One combinational radix-2 Booth iteration (add/sub, then arithmetic shift).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step
  import booth_pkg::*;
#(
  parameter int AW = 5,
  parameter int QW = 4
) (
  input  logic [AW-1:0] a,
  input  logic [QW-1:0] q,
  input  logic          qm1,
  input  logic [AW-1:0] m,
  output logic [AW-1:0] a_nxt,
  output logic [QW-1:0] q_nxt,
  output logic          qm1_nxt
);

  logic [AW-1:0] sum;

  always_comb begin
    sum = a;
    case ({q[0], qm1})
      OP_ADD:  sum = a + m;
      OP_SUB:  sum = a - m;
      default: sum = a;
    endcase
    {a_nxt, q_nxt, qm1_nxt} = {sum[AW-1], sum, q};
  end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mult.sv
// ============================================================================
// Module  : booth_seq_mult
// Brief   : Sequential radix-2 Booth multiplier, one iteration per clock, start/busy/done.
//           Optional macro BOOTH_UNSIGNED_MODE_EN adds an is_signed input for unsigned products.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] z
);

  localparam int AW = WIDTH + 1;
`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int QW = WIDTH + 1;
`else
  localparam int QW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  state_t          state, state_nxt;
  logic [AW-1:0]   a, mr, a_nxt;
  logic [QW-1:0]   qr, q_nxt;
  logic            qm1, qm1_nxt;
  logic [CW-1:0]   count;
  logic            last;
  logic [2*WIDTH-1:0] z_calc;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic            uns;
`endif

  booth_step #(.AW(AW), .QW(QW)) u_step (
    .a       (a),
    .q       (qr),
    .qm1     (qm1),
    .m       (mr),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .qm1_nxt (qm1_nxt)
  );

  assign last = (count == CW'(1));

`ifdef BOOTH_UNSIGNED_MODE_EN
  // Signed runs stop one shift early, leaving the unused sign copy in q_nxt[0].
  assign z_calc = uns ? {a_nxt[WIDTH-2:0], q_nxt}
                      : {a_nxt[WIDTH-1:0], q_nxt[WIDTH:1]};
`else
  assign z_calc = {a_nxt[WIDTH-1:0], q_nxt};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      mr    <= '0;
      qr    <= '0;
      qm1   <= 1'b0;
      count <= '0;
      z     <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
      uns   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a   <= '0;
          qm1 <= 1'b0;
`ifdef BOOTH_UNSIGNED_MODE_EN
          uns <= ~is_signed;
          if (is_signed) begin
            mr    <= {m[WIDTH-1], m};
            qr    <= {q[WIDTH-1], q};
            count <= CW'(WIDTH);
          end else begin
            mr    <= {1'b0, m};
            qr    <= {1'b0, q};
            count <= CW'(WIDTH + 1);
          end
`else
          mr    <= {m[WIDTH-1], m};
          qr    <= q;
          count <= CW'(WIDTH);
`endif
        end
        ST_CALC: begin
          a     <= a_nxt;
          qr    <= q_nxt;
          qm1   <= qm1_nxt;
          count <= count - CW'(1);
          if (last) z <= z_calc;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_mult.sv
// ============================================================================
// Module  : tb_booth_seq_mult
// Brief   : Self-checking bench for booth_seq_mult (WIDTH=4) against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_mult;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   m = '0;
  logic [W-1:0]   q = '0;
  logic           is_s = 1'b1;
  logic           busy, done;
  logic [2*W-1:0] z;
  logic           sg;

  int tests = 0;
  int fails = 0;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .m         (m),
    .q         (q),
`ifdef BOOTH_UNSIGNED_MODE_EN
    .is_signed (is_s),
`endif
    .busy      (busy),
    .done      (done),
    .z         (z)
  );

  always #5 clk = ~clk;

`ifdef BOOTH_UNSIGNED_MODE_EN
  assign sg = is_s;
`else
  assign sg = 1'b1;
`endif

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic int lat(input logic s);
`ifdef BOOTH_UNSIGNED_MODE_EN
    return s ? W : W + 1;
`else
    return (s === 1'b1) ? W : W;
`endif
  endfunction

  // Model: rem = cycles left in the busy window; done is its final cycle
  int             rem = 0;
  logic [2*W-1:0] pend = '0;
  logic [2*W-1:0] ez = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= 0;
      ez  <= '0;
    end else if (rem == 0) begin
      if (start) begin
        rem  <= lat(sg) + 1;
        pend <= prod(m, q, sg);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) ez <= pend;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", {63'd0, busy}, {63'd0, rem != 0});
    chk("done", {63'd0, done}, {63'd0, rem == 1});
    chk("z", {{(64-2*W){1'b0}}, z}, {{(64-2*W){1'b0}}, ez});
  end

  task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int k;
    m = a; q = b; is_s = s; start = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!busy && k < 6);
    if (!busy) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got busy=0 expected busy=1");
    end
    start = 1'b0;
    m = W'($urandom);
    q = W'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
    end
  endtask

  task automatic run_dir(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] want, input logic s, input int wlat);
    int cyc;
    go(a, b, s);
    wait_done(cyc);
    chk("latency", 64'(cyc), 64'(wlat));
    chk("z_literal", {{(64-2*W){1'b0}}, z}, {{(64-2*W){1'b0}}, want});
  endtask

  initial begin
    int cyc;
    int dcnt;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_z", {{(64-2*W){1'b0}}, z}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_dir(4'd4,  4'd6,  8'h18, 1'b1, W);
    run_dir(4'd7,  4'd7,  8'h31, 1'b1, W);
    run_dir(4'd7,  4'hB,  8'hDD, 1'b1, W);
    run_dir(4'hA,  4'hA,  8'h24, 1'b1, W);
    run_dir(4'h8,  4'h8,  8'h40, 1'b1, W);
    run_dir(4'h8,  4'd7,  8'hC8, 1'b1, W);
    run_dir(4'd0,  4'hF,  8'h00, 1'b1, W);
`ifdef BOOTH_UNSIGNED_MODE_EN
    run_dir(4'hF,  4'hF,  8'hE1, 1'b0, W + 1);
    run_dir(4'hF,  4'hF,  8'h01, 1'b1, W);
`endif

    // Second start while busy must be ignored
    go(4'd3, 4'd5, 1'b1);
    @(posedge clk); #1;
    m = 4'd7; q = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0;
    repeat (10) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("done_once", 64'(dcnt), 64'd1);
    chk("ignored_z", {{(64-2*W){1'b0}}, z}, 64'h0F);

    // Abort mid-calculation
    go(4'd5, 4'd3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_z", {{(64-2*W){1'b0}}, z}, 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    dcnt = 0;
    repeat (8) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    run_dir(4'd2, 4'd3, 8'h06, 1'b1, W);

    // Randomised operands, gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef BOOTH_UNSIGNED_MODE_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b1;
`endif
      go(ra, rb, rs);
      wait_done(cyc);
      chk("rand_latency", 64'(cyc), 64'(lat(rs)));
      chk("rand_z", {{(64-2*W){1'b0}}, z}, {{(64-2*W){1'b0}}, prod(ra, rb, rs)});
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
